// File: rtl/address_router_if.sv
// LSU-side and peripheral-side signal bundle for address_router; slot index is p*NUM_LSU+l.
interface address_router_if #(
   parameter int unsigned INTERFACE_WIDTH      = 32,
   parameter int unsigned INTERFACE_ADDR_WIDTH = 32,
   parameter int unsigned NUM_PERIPHERALS      = 2,
   parameter int unsigned NUM_LSU              = 1
);
   localparam int unsigned W  = INTERFACE_WIDTH;
   localparam int unsigned AW = INTERFACE_ADDR_WIDTH;
   localparam int unsigned NP = NUM_PERIPHERALS;
   localparam int unsigned NL = NUM_LSU;
   localparam int unsigned BE = W / 8;

   // LSU side
   logic [NL*AW-1:0]    iReadAddress;
   logic [NL*AW-1:0]    iWriteAddress;
   logic [NL*W-1:0]     iWriteData;
   logic [NL*BE-1:0]    iWriteEnable;
   logic [NL-1:0]       iReadRequest;
   logic [NL-1:0]       iWriteRequest;
   logic [NL*W-1:0]     oReadData;
   logic [NL-1:0]       oReadDataValid;
   logic [NL-1:0]       oWriteAccept;
   logic [NL-1:0]       oReadGrantNextCycle;
   logic [NL-1:0]       oWriteGrantNextCycle;
   logic [NL-1:0]       oError;

   // Peripheral side
   logic [NP*NL*AW-1:0] oPReadAddress;
   logic [NP*NL*AW-1:0] oPWriteAddress;
   logic [NP*NL*W-1:0]  oPWriteData;
   logic [NP*NL*BE-1:0] oPWriteEnable;
   logic [NP*NL-1:0]    oPReadRequest;
   logic [NP*NL-1:0]    oPWriteRequest;
   logic [NP*NL*W-1:0]  iPReadData;
   logic [NP*NL-1:0]    iPReadDataValid;
   logic [NP*NL-1:0]    iPWriteAccept;
   logic [NP*NL-1:0]    iPReadGrantNextCycle;
   logic [NP*NL-1:0]    iPWriteGrantNextCycle;

   modport slave (
      input  iReadAddress, iWriteAddress, iWriteData, iWriteEnable, iReadRequest, iWriteRequest,
      output oReadData, oReadDataValid, oWriteAccept, oReadGrantNextCycle, oWriteGrantNextCycle, oError,
      output oPReadAddress, oPWriteAddress, oPWriteData, oPWriteEnable, oPReadRequest, oPWriteRequest,
      input  iPReadData, iPReadDataValid, iPWriteAccept, iPReadGrantNextCycle, iPWriteGrantNextCycle
   );

   modport master (
      output iReadAddress, iWriteAddress, iWriteData, iWriteEnable, iReadRequest, iWriteRequest,
      input  oReadData, oReadDataValid, oWriteAccept, oReadGrantNextCycle, oWriteGrantNextCycle, oError,
      input  oPReadAddress, oPWriteAddress, oPWriteData, oPWriteEnable, oPReadRequest, oPWriteRequest,
      output iPReadData, iPReadDataValid, iPWriteAccept, iPReadGrantNextCycle, iPWriteGrantNextCycle
   );
endinterface

// File: rtl/address_router.sv
// Routes NUM_LSU independent load/store ports onto NUM_PERIPHERALS address ranges,
// returning read data in issue order and flagging accesses to unmapped addresses.
module address_router #(
   parameter int unsigned INTERFACE_WIDTH      = 32,
   parameter int unsigned INTERFACE_ADDR_WIDTH = 32,
   parameter int unsigned NUM_PERIPHERALS      = 2,
   parameter int unsigned NUM_LSU              = 1,
   parameter logic [NUM_PERIPHERALS*INTERFACE_ADDR_WIDTH-1:0] PERIPHERAL_BASE = {32'd512, 32'd0},
   parameter logic [NUM_PERIPHERALS*INTERFACE_ADDR_WIDTH-1:0] PERIPHERAL_SIZE = {32'd512, 32'd512},
   parameter int unsigned OUTSTANDING_DEPTH    = 4
) (
   input logic             iClk,
   input logic             iReset_n,
   address_router_if.slave bus
);
   localparam int unsigned W    = INTERFACE_WIDTH;
   localparam int unsigned AW   = INTERFACE_ADDR_WIDTH;
   localparam int unsigned NP   = NUM_PERIPHERALS;
   localparam int unsigned NL   = NUM_LSU;
   localparam int unsigned BE   = W / 8;
   localparam int unsigned PW   = (NP > 1) ? $clog2(NP) : 1;
   localparam int unsigned PTRW = $clog2(OUTSTANDING_DEPTH);
   localparam int unsigned CW   = PTRW + 1;
   localparam int unsigned EW   = PW + 1;

   // One-hot range match, lowest index wins on overlap; compare is AW+1 bits so base+size cannot wrap.
   function automatic logic [NP-1:0] decode(input logic [AW-1:0] addr);
      logic [NP-1:0] sel;
      logic [AW:0]   lo;
      logic [AW:0]   hi;
      sel = '0;
      for (int p = int'(NP) - 1; p >= 0; p--) begin
         lo = {1'b0, PERIPHERAL_BASE[p*AW +: AW]};
         hi = lo + {1'b0, PERIPHERAL_SIZE[p*AW +: AW]};
         if (({1'b0, addr} >= lo) && ({1'b0, addr} < hi)) sel = NP'(1) << p;
      end
      return sel;
   endfunction

   function automatic logic [PW-1:0] encode(input logic [NP-1:0] sel);
      logic [PW-1:0] idx;
      idx = '0;
      for (int p = 0; p < int'(NP); p++) begin
         if (sel[p]) idx = PW'(p);
      end
      return idx;
   endfunction

   logic [NL-1:0]       rd_gnt_q, rd_gnt_d;
   logic [NL-1:0]       wr_gnt_q, wr_gnt_d;
   logic [CW-1:0]       count_q [NL];
   logic [CW-1:0]       count_d [NL];
   logic [PTRW-1:0]     wptr_q  [NL];
   logic [PTRW-1:0]     wptr_d  [NL];
   logic [PTRW-1:0]     rptr_q  [NL];
   logic [PTRW-1:0]     rptr_d  [NL];
   logic [EW-1:0]       fifo_q  [NL][OUTSTANDING_DEPTH];
   logic [EW-1:0]       fifo_d  [NL][OUTSTANDING_DEPTH];
   logic [NL-1:0]       rvalid_q, rvalid_d;
   logic [NL*W-1:0]     rdata_q, rdata_d;
   logic [NL-1:0]       wacc_q, wacc_d;
   logic [NL-1:0]       err_q, err_d;

   logic [NP*NL*AW-1:0] rd_paddr_c, wr_paddr_c;
   logic [NP*NL*W-1:0]  wr_pdata_c;
   logic [NP*NL*BE-1:0] wr_pbe_c;
   logic [NP*NL-1:0]    rd_preq_c, wr_preq_c;
   logic [NL-1:0]       rd_grant_c, wr_grant_c;

   // Per-LSU decode, request/grant steering, tracking FIFO and response selection.
   always_comb begin : comb_p
      logic [AW-1:0] rd_addr;
      logic [AW-1:0] wr_addr;
      logic [NP-1:0] rd_sel;
      logic [NP-1:0] wr_sel;
      logic          rd_unm, wr_unm, full, rd_gnt, wr_gnt;
      logic          push, pop, rd_err, wr_err, wr_acc;
      logic [EW-1:0] head;
      int unsigned   s;

      rd_paddr_c = '0;
      wr_paddr_c = '0;
      wr_pdata_c = '0;
      wr_pbe_c   = '0;
      rd_preq_c  = '0;
      wr_preq_c  = '0;
      rd_grant_c = '0;
      wr_grant_c = '0;
      rd_gnt_d   = '0;
      wr_gnt_d   = '0;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      fifo_d     = fifo_q;
      rvalid_d   = '0;
      rdata_d    = rdata_q;
      wacc_d     = '0;
      err_d      = '0;

      for (int l = 0; l < int'(NL); l++) begin
         rd_addr = bus.iReadAddress[l*AW +: AW];
         wr_addr = bus.iWriteAddress[l*AW +: AW];
         rd_sel  = decode(rd_addr);
         wr_sel  = decode(wr_addr);
         rd_unm  = (rd_sel == '0);
         wr_unm  = (wr_sel == '0);
         full    = (count_q[l] == CW'(OUTSTANDING_DEPTH));
         rd_gnt  = ~full & rd_unm;
         wr_gnt  = wr_unm;
         wr_acc  = 1'b0;
         head    = fifo_q[l][rptr_q[l]];
         pop     = 1'b0;
         rd_err  = 1'b0;

         for (int p = 0; p < int'(NP); p++) begin
            s = 32'(p) * NL + 32'(l);
            if (rd_sel[p]) begin
               rd_paddr_c[s*AW +: AW] = rd_addr - PERIPHERAL_BASE[p*AW +: AW];
               rd_preq_c[s]           = bus.iReadRequest[l] & ~full;
               rd_gnt                 = ~full & bus.iPReadGrantNextCycle[s];
            end
            if (wr_sel[p]) begin
               wr_paddr_c[s*AW +: AW] = wr_addr - PERIPHERAL_BASE[p*AW +: AW];
               wr_pdata_c[s*W +: W]   = bus.iWriteData[l*W +: W];
               wr_pbe_c[s*BE +: BE]   = bus.iWriteEnable[l*BE +: BE];
               wr_preq_c[s]           = bus.iWriteRequest[l];
               wr_gnt                 = bus.iPWriteGrantNextCycle[s];
            end
            wr_acc = wr_acc | bus.iPWriteAccept[s];
            // Only the slot at the head of the in-order queue may complete a read.
            if ((count_q[l] != '0) && !head[EW-1] && (head[PW-1:0] == PW'(p))
                && bus.iPReadDataValid[s]) begin
               pop                  = 1'b1;
               rdata_d[l*W +: W]    = bus.iPReadData[s*W +: W];
            end
         end

         if ((count_q[l] != '0) && head[EW-1]) begin
            pop               = 1'b1;
            rd_err            = 1'b1;
            rdata_d[l*W +: W] = '0;
         end

         rd_grant_c[l] = rd_gnt;
         wr_grant_c[l] = wr_gnt;
         rd_gnt_d[l]   = rd_gnt;
         wr_gnt_d[l]   = wr_gnt;

         // Full also blocks the push so a grant issued one slot early cannot overflow.
         push   = bus.iReadRequest[l] & rd_gnt_q[l] & ~full;
         wr_err = bus.iWriteRequest[l] & wr_gnt_q[l] & wr_unm;

         if (push) begin
            fifo_d[l][wptr_q[l]] = {rd_unm, encode(rd_sel)};
            wptr_d[l]            = wptr_q[l] + PTRW'(1);
         end
         if (pop) rptr_d[l] = rptr_q[l] + PTRW'(1);
         if (push && !pop)      count_d[l] = count_q[l] + CW'(1);
         else if (!push && pop) count_d[l] = count_q[l] - CW'(1);

         rvalid_d[l] = pop;
         wacc_d[l]   = wr_acc | wr_err;
         err_d[l]    = rd_err | wr_err;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         rd_gnt_q <= '0;
         wr_gnt_q <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         wacc_q   <= '0;
         err_q    <= '0;
         for (int l = 0; l < int'(NL); l++) begin
            count_q[l] <= '0;
            wptr_q[l]  <= '0;
            rptr_q[l]  <= '0;
            for (int d = 0; d < int'(OUTSTANDING_DEPTH); d++) fifo_q[l][d] <= '0;
         end
      end else begin
         rd_gnt_q <= rd_gnt_d;
         wr_gnt_q <= wr_gnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         wacc_q   <= wacc_d;
         err_q    <= err_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         fifo_q   <= fifo_d;
      end
   end

   assign bus.oReadData            = rdata_q;
   assign bus.oReadDataValid       = rvalid_q;
   assign bus.oWriteAccept         = wacc_q;
   assign bus.oError               = err_q;
   assign bus.oReadGrantNextCycle  = rd_grant_c;
   assign bus.oWriteGrantNextCycle = wr_grant_c;
   assign bus.oPReadAddress        = rd_paddr_c;
   assign bus.oPWriteAddress       = wr_paddr_c;
   assign bus.oPWriteData          = wr_pdata_c;
   assign bus.oPWriteEnable        = wr_pbe_c;
   assign bus.oPReadRequest        = rd_preq_c;
   assign bus.oPWriteRequest       = wr_preq_c;

endmodule

// File: tb/tb_address_router.sv
// Directed bench for address_router with default parameters (two ranges, one LSU).
module tb_address_router;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   address_router_if #(
      .INTERFACE_WIDTH(32), .INTERFACE_ADDR_WIDTH(32), .NUM_PERIPHERALS(2), .NUM_LSU(1)
   ) bus ();

   address_router dut (
      .iClk    (clk),
      .iReset_n(rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.iReadAddress          = '0;
      bus.iWriteAddress         = '0;
      bus.iWriteData            = '0;
      bus.iWriteEnable          = '0;
      bus.iReadRequest          = '0;
      bus.iWriteRequest         = '0;
      bus.iPReadData            = '0;
      bus.iPReadDataValid       = '0;
      bus.iPWriteAccept         = '0;
      bus.iPReadGrantNextCycle  = 2'b11;
      bus.iPWriteGrantNextCycle = 2'b11;
      repeat (3) cyc();

      // Reset state and range boundaries (combinational, checked while held in reset)
      chk("rst_rvalid", 64'(bus.oReadDataValid), 64'h0);
      chk("rst_rdata",  64'(bus.oReadData),      64'h0);
      chk("rst_wacc",   64'(bus.oWriteAccept),   64'h0);
      chk("rst_err",    64'(bus.oError),         64'h0);
      bus.iReadRequest = 1'b1;
      bus.iReadAddress = 32'h1FF; #1;
      chk("bnd_1ff_req",  64'(bus.oPReadRequest), 64'h1);
      chk("bnd_1ff_addr", 64'(bus.oPReadAddress), 64'h0000_0000_0000_01FF);
      bus.iReadAddress = 32'h200; #1;
      chk("bnd_200_req",  64'(bus.oPReadRequest), 64'h2);
      chk("bnd_200_addr", 64'(bus.oPReadAddress), 64'h0);
      bus.iReadAddress = 32'h3FF; #1;
      chk("bnd_3ff_addr", 64'(bus.oPReadAddress), 64'h0000_01FF_0000_0000);
      bus.iReadAddress = 32'h400; #1;
      chk("bnd_400_req",  64'(bus.oPReadRequest), 64'h0);
      chk("bnd_400_gnt",  64'(bus.oReadGrantNextCycle), 64'h1);
      cyc();
      bus.iReadRequest = 1'b0;
      bus.iReadAddress = 32'h004;
      bus.iPReadGrantNextCycle = 2'b10; #1;
      chk("gnt_follow_periph", 64'(bus.oReadGrantNextCycle), 64'h0);
      bus.iPReadGrantNextCycle = 2'b11;
      rst_n = 1'b1;

      // Mapped read to slot1
      cyc();
      bus.iReadAddress = 32'h204;
      bus.iReadRequest = 1'b1; #1;
      chk("rd204_req",  64'(bus.oPReadRequest), 64'h2);
      chk("rd204_addr", 64'(bus.oPReadAddress), 64'h0000_0004_0000_0000);
      cyc();
      bus.iReadRequest    = 1'b0;
      bus.iPReadData      = {32'h0000_CAFE, 32'h0};
      bus.iPReadDataValid = 2'b10; #1;
      chk("rd204_novalid_yet", 64'(bus.oReadDataValid), 64'h0);
      cyc();
      bus.iPReadDataValid = 2'b00; #1;
      chk("rd204_valid", 64'(bus.oReadDataValid), 64'h1);
      chk("rd204_data",  64'(bus.oReadData),      64'hCAFE);
      chk("rd204_noerr", 64'(bus.oError),         64'h0);
      cyc(); #1;
      chk("rd204_valid_drop", 64'(bus.oReadDataValid), 64'h0);

      // Unmapped read
      cyc();
      bus.iReadAddress = 32'h1000;
      bus.iReadRequest = 1'b1; #1;
      chk("rd1000_noreq", 64'(bus.oPReadRequest), 64'h0);
      cyc();
      bus.iReadRequest = 1'b0; #1;
      chk("rd1000_wait", 64'(bus.oReadDataValid), 64'h0);
      cyc(); #1;
      chk("rd1000_valid", 64'(bus.oReadDataValid), 64'h1);
      chk("rd1000_data",  64'(bus.oReadData),      64'h0);
      chk("rd1000_err",   64'(bus.oError),         64'h1);
      cyc(); #1;
      chk("rd1000_err_drop", 64'(bus.oError), 64'h0);

      // Fill the tracking FIFO with a stalled peripheral
      cyc();
      bus.iReadAddress = 32'h004;
      bus.iReadRequest = 1'b1; #1;
      chk("fill_gnt0", 64'(bus.oReadGrantNextCycle), 64'h1);
      repeat (4) cyc();
      #1;
      chk("full_gnt", 64'(bus.oReadGrantNextCycle), 64'h0);
      chk("full_req", 64'(bus.oPReadRequest),       64'h0);
      cyc(); #1;
      chk("full_req2", 64'(bus.oPReadRequest), 64'h0);
      bus.iPReadData      = 64'h11;
      bus.iPReadDataValid = 2'b01;
      cyc();
      bus.iPReadDataValid = 2'b00; #1;
      chk("pop_valid", 64'(bus.oReadDataValid), 64'h1);
      chk("pop_data",  64'(bus.oReadData),      64'h11);
      chk("pop_req",   64'(bus.oPReadRequest),  64'h1);
      chk("pop_gnt",   64'(bus.oReadGrantNextCycle), 64'h1);
      cyc();
      cyc();
      bus.iReadRequest = 1'b0; #1;
      chk("refull_gnt", 64'(bus.oReadGrantNextCycle), 64'h0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         bus.iPReadData      = 64'(32'h21 + 32'(k));
         bus.iPReadDataValid = 2'b01; #1;
         if (k > 0) chk("drain_data", 64'(bus.oReadData), 64'(32'h20 + 32'(k)));
      end
      cyc();
      bus.iPReadDataValid = 2'b00; #1;
      chk("drain_last",  64'(bus.oReadData),           64'h24);
      chk("drain_gnt",   64'(bus.oReadGrantNextCycle), 64'h1);
      cyc();
      bus.iPReadData      = 64'h99;
      bus.iPReadDataValid = 2'b01;
      cyc();
      bus.iPReadDataValid = 2'b00; #1;
      chk("stray_ignored", 64'(bus.oReadDataValid), 64'h0);

      // In-order return across slots
      cyc();
      bus.iReadAddress = 32'h008;
      bus.iReadRequest = 1'b1;
      cyc();
      bus.iReadAddress = 32'h208; #1;
      chk("ord_req1",  64'(bus.oPReadRequest), 64'h2);
      chk("ord_addr1", 64'(bus.oPReadAddress), 64'h0000_0008_0000_0000);
      cyc();
      bus.iReadRequest    = 1'b0;
      bus.iPReadData      = {32'h0000_BBBB, 32'h0000_AAAA};
      bus.iPReadDataValid = 2'b10;
      cyc();
      bus.iPReadDataValid = 2'b01; #1;
      chk("ord_nonhead_ignored", 64'(bus.oReadDataValid), 64'h0);
      cyc();
      bus.iPReadDataValid = 2'b10; #1;
      chk("ord_first_valid", 64'(bus.oReadDataValid), 64'h1);
      chk("ord_first_data",  64'(bus.oReadData),      64'hAAAA);
      cyc();
      bus.iPReadDataValid = 2'b00; #1;
      chk("ord_second_valid", 64'(bus.oReadDataValid), 64'h1);
      chk("ord_second_data",  64'(bus.oReadData),      64'hBBBB);

      // Writes
      cyc();
      bus.iWriteAddress         = 32'h010;
      bus.iPWriteGrantNextCycle = 2'b10; #1;
      chk("wr_gnt_follow", 64'(bus.oWriteGrantNextCycle), 64'h0);
      bus.iPWriteGrantNextCycle = 2'b11;
      cyc();
      bus.iWriteData    = 32'h1234_5678;
      bus.iWriteEnable  = 4'hF;
      bus.iWriteRequest = 1'b1; #1;
      chk("wr_req",  64'(bus.oPWriteRequest), 64'h1);
      chk("wr_addr", 64'(bus.oPWriteAddress), 64'h10);
      chk("wr_data", 64'(bus.oPWriteData),    64'h1234_5678);
      chk("wr_be",   64'(bus.oPWriteEnable),  64'h0F);
      cyc();
      bus.iWriteRequest = 1'b0;
      bus.iPWriteAccept = 2'b01; #1;
      chk("wr_acc_wait", 64'(bus.oWriteAccept), 64'h0);
      cyc();
      bus.iPWriteAccept = 2'b00; #1;
      chk("wr_acc",   64'(bus.oWriteAccept), 64'h1);
      chk("wr_noerr", 64'(bus.oError),       64'h0);
      cyc();
      bus.iWriteAddress = 32'h800;
      bus.iWriteRequest = 1'b1; #1;
      chk("wr800_noreq", 64'(bus.oPWriteRequest),       64'h0);
      chk("wr800_gnt",   64'(bus.oWriteGrantNextCycle), 64'h1);
      cyc();
      bus.iWriteRequest = 1'b0; #1;
      chk("wr800_acc", 64'(bus.oWriteAccept), 64'h1);
      chk("wr800_err", 64'(bus.oError),       64'h1);
      cyc(); #1;
      chk("wr800_err_drop", 64'(bus.oError), 64'h0);

      // Reset with three reads outstanding
      cyc();
      bus.iReadAddress = 32'h004;
      bus.iReadRequest = 1'b1;
      repeat (3) cyc();
      bus.iReadRequest    = 1'b0;
      bus.iPWriteAccept   = 2'b01;
      bus.iPReadData      = 64'h77;
      bus.iPReadDataValid = 2'b01;
      rst_n = 1'b0;
      cyc();
      bus.iPWriteAccept   = 2'b00;
      bus.iPReadDataValid = 2'b00; #1;
      chk("mrst_rvalid", 64'(bus.oReadDataValid), 64'h0);
      chk("mrst_rdata",  64'(bus.oReadData),      64'h0);
      chk("mrst_wacc",   64'(bus.oWriteAccept),   64'h0);
      chk("mrst_err",    64'(bus.oError),         64'h0);
      chk("mrst_gnt",    64'(bus.oReadGrantNextCycle), 64'h1);
      rst_n = 1'b1;
      bus.iPReadData      = 64'h5555;
      bus.iPReadDataValid = 2'b01;
      cyc(); #1;
      chk("late_resp1", 64'(bus.oReadDataValid), 64'h0);
      cyc(); #1;
      chk("late_resp2", 64'(bus.oReadDataValid), 64'h0);
      bus.iPReadDataValid = 2'b00;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/address_router.md
ADDRESS_ROUTER -- requirements
Module: address_router

Interface
REQ-001 SHALL have parameter INTERFACE_WIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter INTERFACE_ADDR_WIDTH, default 32, address width (AW).
REQ-003 SHALL have parameter NUM_PERIPHERALS, default 2, number of target ranges (NP).
REQ-004 SHALL have parameter NUM_LSU, default 1, number of independent LSU ports (NL).
REQ-005 SHALL have parameter PERIPHERAL_BASE, default {32'd512, 32'd0}, packed NP*AW range bases, peripheral p at [p*AW +: AW].
REQ-006 SHALL have parameter PERIPHERAL_SIZE, default {32'd512, 32'd512}, packed NP*AW range sizes in address units.
REQ-007 SHALL have parameter OUTSTANDING_DEPTH, default 4, per-LSU read-tracking depth (power of two, >=2).
REQ-008 iClk  in  1  clock; all state on rising edge.
REQ-009 iReset_n  in  1  reset, synchronous, active-low.
REQ-010 iReadAddress/iWriteAddress  in  NL*AW; iWriteData  in  NL*W; iWriteEnable  in  NL*(W/8); iReadRequest/iWriteRequest  in  NL.
REQ-011 oReadData  out  NL*W; oReadDataValid, oWriteAccept, oReadGrantNextCycle, oWriteGrantNextCycle, oError  out  NL each.
REQ-012 oPReadAddress/oPWriteAddress  out  NP*NL*AW; oPWriteData  out  NP*NL*W; oPWriteEnable  out  NP*NL*(W/8); oPReadRequest/oPWriteRequest  out  NP*NL; slot index p*NL+l.
REQ-013 iPReadData  in  NP*NL*W; iPReadDataValid, iPWriteAccept, iPReadGrantNextCycle, iPWriteGrantNextCycle  in  NP*NL; same slot indexing.

Function
REQ-014 Decode SHALL be combinational per LSU: hit[p] = addr >= BASE[p] && addr < BASE[p]+SIZE[p] (AW+1-bit compare); lowest p wins on overlap; no hit = unmapped.
REQ-015 Forwarded addresses SHALL be addr - BASE[p], AW bits; data and byte enables passed unchanged to the hit slot only; non-hit slots see request 0.
REQ-016 oPReadRequest[p,l] SHALL = iReadRequest[l] & hit[p] & ~full[l]; oPWriteRequest[p,l] = iWriteRequest[l] & hit[p].
REQ-017 oReadGrantNextCycle[l] SHALL = 0 when full[l], else iPReadGrantNextCycle of hit slot, else 1 when unmapped; oWriteGrantNextCycle likewise without full term.
REQ-018 A read SHALL be accepted in cycle t iff iReadRequest[l]=1 and oReadGrantNextCycle[l] was 1 in cycle t-1 (registered copy).
REQ-019 Each accepted read SHALL push {unmapped, p} into an in-order per-LSU tracking FIFO; full[l] when count = OUTSTANDING_DEPTH.
REQ-020 Head mapped: iPReadDataValid of the head slot SHALL be registered to oReadDataValid/oReadData one cycle later and pop the head; valids from non-head slots ignored.
REQ-021 Head unmapped: one cycle after reaching head SHALL emit oReadDataValid=1, oReadData=0, oError=1 for one cycle, and pop.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers wrap modulo OUTSTANDING_DEPTH.
REQ-023 oWriteAccept[l] SHALL be the registered OR of iPWriteAccept over slots of LSU l (1-cycle latency).
REQ-024 Accepted unmapped write (same rule as REQ-018 with write grant) SHALL produce oWriteAccept=1 and oError=1 next cycle; no peripheral request.
REQ-025 Read-error and write-error in the same cycle SHALL both drive oError=1 (single pulse).
REQ-026 LSU ports SHALL be fully independent; no arbitration between LSUs (per-slot wiring).

Reset
REQ-027 While iReset_n=0 at an edge: FIFO count/pointers 0, registered grants 0, oReadDataValid, oReadData, oWriteAccept, oError 0.
REQ-028 Reset mid-operation SHALL drop all outstanding reads; responses arriving after reset release SHALL be ignored.
REQ-029 Combinational outputs (requests, grants) SHALL depend on inputs only, gated by full, which is 0 after reset.

Verification
REQ-030 Default params, read 0x204 with grant -> oPReadRequest slot1, address 0x004; peripheral valid data 0xCAFE -> oReadDataValid with 0xCAFE one cycle later.
REQ-031 Read 0x1000 (unmapped) -> no peripheral request, 0x0 data with valid and oError one cycle after reaching head.
REQ-032 Issue 4 reads, peripheral stalls -> count=4, oReadGrantNextCycle=0, 5th read not forwarded until one response pops.
REQ-033 Reads to slot0 then slot1; slot1 answers first -> ignored, slot0 data returned, then slot1 re-answer returned in order.
REQ-034 Write 0x010 data 0x12345678 enable 0xF -> slot0 sees 0x010 request; iPWriteAccept -> oWriteAccept next cycle; write 0x800 -> accept+oError.
REQ-035 Assert iReset_n=0 with 3 reads outstanding -> count 0, all registered outputs 0; late iPReadDataValid produces no oReadDataValid.
